// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into word-wide memory transactions.
// Latency (accept cycle to rsp_valid): error 1, SW 2, load 3, SB/SH 4 (read-modify-write).
// Backpressure: req_ready is high only in IDLE; responses cannot be stalled.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req_*              - request (valid/ready, store, funct3, byte address, right-aligned write data)
//   rsp_*              - one-cycle completion pulse with load data and error flag
//   mem_*              - single-port data memory with word write enable and registered read
//   stat_* (optional)  - load/store/error counters, present only when LSU_STATS_EN is defined
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic                     mem_we,
  input  logic [DATA_WIDTH-1:0]    mem_rd
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]              stat_loads,
  output logic [31:0]              stat_stores,
  output logic [31:0]              stat_errors
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  // Request fields latched at accept
  logic [1:0]              r_addr_lo;
  logic [2:0]              r_funct3;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_store;

  logic                    w_accept;
  logic                    w_bad_funct3;
  logic                    w_misalign;
  logic                    w_req_err;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && req_valid;

  // Loads allow 0,1,2,4,5; stores allow 0,1,2. funct3[1:0] encodes the access size.
  assign w_bad_funct3 = req_store ? (req_funct3 > 3'd2)
                                  : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign w_misalign   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_req_err    = w_bad_funct3 || w_misalign;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_next = S_RESP;
          end else if (req_store && (req_funct3 == 3'd2)) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE:   w_next = S_CAPTURE;
      // Sub-word stores go on to write back the merged word
      S_CAPTURE: w_next = r_store ? S_WRITE : S_RESP;
      S_WRITE:   w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from mem_rd in CAPTURE
  always_comb begin
    w_byte      = 8'h00;
    w_half      = r_addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
    w_load_data = mem_rd;
    w_merged    = r_wdata;
    case (r_addr_lo)
      2'd0:    w_byte = mem_rd[7:0];
      2'd1:    w_byte = mem_rd[15:8];
      2'd2:    w_byte = mem_rd[23:16];
      default: w_byte = mem_rd[31:24];
    endcase
    case (r_funct3[1:0])
      2'd0: begin
        w_load_data = r_funct3[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_merged    = mem_rd;
        case (r_addr_lo)
          2'd0:    w_merged[7:0]   = r_wdata[7:0];
          2'd1:    w_merged[15:8]  = r_wdata[7:0];
          2'd2:    w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      2'd1: begin
        w_load_data = r_funct3[2] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        w_merged    = mem_rd;
        if (r_addr_lo[1]) begin
          w_merged[31:16] = r_wdata[15:0];
        end else begin
          w_merged[15:0]  = r_wdata[15:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr_lo <= 2'b00;
      r_funct3  <= 3'd0;
      r_wdata   <= '0;
      r_store   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      r_state   <= w_next;
      mem_we    <= (w_next == S_WRITE);
      rsp_valid <= (w_next == S_RESP);

      if (w_accept) begin
        r_addr_lo <= req_addr[1:0];
        r_funct3  <= req_funct3;
        r_wdata   <= req_wdata;
        r_store   <= req_store;
        // Only a real memory access moves mem_addr; it then holds through ISSUE/WRITE and after
        if (!w_req_err) begin
          mem_addr <= {2'b00, req_addr[ADDRESS_WIDTH-1:2]};
        end
        if (req_store && (req_funct3 == 3'd2)) begin
          mem_wd <= req_wdata;
        end
      end

      if ((r_state == S_CAPTURE) && r_store) begin
        mem_wd <= w_merged;
      end

      // Response fields are nonzero only while rsp_valid is high
      if (w_next == S_RESP) begin
        rsp_err  <= (r_state == S_IDLE);
        rsp_data <= ((r_state == S_CAPTURE) && !r_store) ? w_load_data : '0;
      end else begin
        rsp_err  <= 1'b0;
        rsp_data <= '0;
      end
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errors <= 32'd0;
    end else if (r_state == S_RESP) begin
      if (rsp_err) begin
        stat_errors <= stat_errors + 32'd1;
      end else if (r_store) begin
        stat_stores <= stat_stores + 32'd1;
      end else begin
        stat_loads  <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
`ifdef LSU_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_errors;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
  );

  // Memory seen by the DUT: registered read, word write. Word indices used by the
  // stimulus (0..31 and 0x3FFFFFFF) are distinct in their low 6 bits.
  logic [31:0] dmem [64];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else if (mem_we) begin
      dmem[mem_addr[5:0]] <= mem_wd;
    end
    mem_rd <= dmem[mem_addr[5:0]];
  end

  // Reference memory image, updated only by the model
  logic [31:0] rmem [64];

  int checks = 0;
  int errors = 0;
  int m_loads = 0, m_stores = 0, m_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_junk();
    req_valid  = 1'($urandom_range(0, 1));
    req_store  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Issues one request at the current negedge (unit idle) and checks every cycle up to
  // and including the first idle cycle afterwards. Returns the observed response.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_data, output logic got_err);
    logic        e_err;
    logic [31:0] e_data, e_word, idx, word, b, h;
    int          lat, wr_cyc;
    logic        reads;
    idx    = addr >> 2;
    word   = rmem[idx[5:0]];
    e_err  = (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
             (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    e_data = 32'h0;
    e_word = word;
    wr_cyc = -1;
    reads  = 1'b0;
    got_data = 32'h0;
    got_err  = 1'b0;
    if (e_err) begin
      lat = 1;
    end else if (!st) begin
      lat   = 3;
      reads = 1'b1;
      b = (word >> (8 * addr[1:0])) & 32'hFF;
      h = (word >> (16 * addr[1])) & 32'hFFFF;
      case (f3)
        3'd0:    e_data = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
        3'd4:    e_data = b;
        3'd1:    e_data = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
        3'd5:    e_data = h;
        default: e_data = word;
      endcase
    end else if (f3 == 3'd2) begin
      lat = 2; wr_cyc = 1;
      e_word = wd;
    end else begin
      lat = 4; wr_cyc = 3; reads = 1'b1;
      if (f3 == 3'd0)
        e_word = (word & ~(32'hFF << (8 * addr[1:0]))) | ((wd & 32'hFF) << (8 * addr[1:0]));
      else
        e_word = (word & ~(32'hFFFF << (16 * addr[1]))) | ((wd & 32'hFFFF) << (16 * addr[1]));
    end

    chk("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk("req_ready", 32'(req_ready), (k <= lat) ? 32'd1 - 32'd1 : 32'd1);
      chk("mem_we", 32'(mem_we), (k == wr_cyc) ? 32'd1 : 32'd0);
      if (k == wr_cyc) begin
        chk("wr_mem_addr", mem_addr, idx);
        chk("wr_mem_wd", mem_wd, e_word);
      end
      if (k == 1 && reads) chk("issue_mem_addr", mem_addr, idx);
      chk("rsp_valid", 32'(rsp_valid), (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_data", rsp_data, e_data);
        got_data = rsp_data;
        got_err  = rsp_err;
      end
      if (k <= lat) drive_junk();
      else          req_valid = 1'b0;
      if (k <= lat) @(posedge clk);
    end
    if (e_err)   m_errs++;
    else if (st) m_stores++;
    else         m_loads++;
    if (!e_err && st) rmem[idx[5:0]] = e_word;
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    for (int i = 0; i < 64; i++) rmem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wd", mem_wd, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    // Directed sequence with hand-computed literal expectations
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, d, e);
    chk("dmem_sw", dmem[4], 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, d, e);  chk("lit_lb",  d, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, d, e);  chk("lit_lbu", d, 32'h000000DE);
    do_req(1'b0, 3'd1, 32'h10, 32'h0, d, e);  chk("lit_lh",  d, 32'hFFFFBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, d, e);  chk("lit_lw",  d, 32'hDEADBEEF);
    do_req(1'b1, 3'd0, 32'h11, 32'h12, d, e);
    chk("lit_sb_mem", dmem[4], 32'hDEAD12EF);
    do_req(1'b1, 3'd1, 32'h12, 32'hCAFE, d, e);
    chk("lit_sh_mem", dmem[4], 32'hCAFE12EF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, d, e);  chk("lit_lw2", d, 32'hCAFE12EF);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, d, e);  chk("lit_lw_mis_err", 32'(e), 32'd1);
    do_req(1'b0, 3'd1, 32'h11, 32'h0, d, e);  chk("lit_lh_mis_err", 32'(e), 32'd1);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, d, e);  chk("lit_f3_err", 32'(e), 32'd1);
    do_req(1'b1, 3'd3, 32'h10, 32'h0, d, e);  chk("lit_st_f3_err", 32'(e), 32'd1);
    chk("err_mem_intact", dmem[4], 32'hCAFE12EF);
    // Top of the address space maps to word index 0x3FFFFFFF
    do_req(1'b1, 3'd2, 32'hFFFFFFFC, 32'h5A5A1234, d, e);
    do_req(1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, d, e); chk("lit_lb_top", d, 32'h0000005A);
    do_req(1'b0, 3'd5, 32'hFFFFFFFE, 32'h0, d, e); chk("lit_lhu_top", d, 32'h00005A5A);

    // Reset during the CAPTURE cycle of an SB: no write, no response
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h77;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("abort_mem_word", dmem[4], rmem[4]);
    m_loads = 0; m_stores = 0; m_errs = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      else                           a = 32'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, d, e);
    end
    for (int i = 0; i < 32; i++) chk("final_mem", dmem[i], rmem[i]);
    chk("final_mem_top", dmem[63], rmem[63]);

`ifdef LSU_STATS_EN
    chk("stat_loads", stat_loads, 32'(m_loads));
    chk("stat_stores", stat_stores, 32'(m_stores));
    chk("stat_errors", stat_errors, 32'(m_errs));
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_loads = 0; m_stores = 0; m_errs = 0;
    do_req(1'b0, 3'd2, 32'h10, 32'h0, d, e);
    do_req(1'b0, 3'd4, 32'h11, 32'h0, d, e);
    do_req(1'b1, 3'd2, 32'h20, 32'h1, d, e);
    do_req(1'b0, 3'd2, 32'h21, 32'h0, d, e);
    @(negedge clk);
    chk("lit_stat_loads", stat_loads, 32'd2);
    chk("lit_stat_stores", stat_stores, 32'd1);
    chk("lit_stat_errors", stat_errors, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("stat_clr", stat_loads | stat_stores | stat_errors, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
